// File: rtl/parity3_pkg.sv
// ============================================================================
// Module      : parity3_pkg
// Description : Shared types and defaults for the parity3 frame accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity3_pkg;

    localparam int BEAT_W        = 3;
    localparam int DEF_MAX_BEATS = 16;
    localparam int DEF_CNT_W     = 8;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/parity3_fold.sv
// ============================================================================
// Module      : parity3_fold
// Description : Folds one 3-bit beat into the running odd-parity accumulator
//               and gives the even-parity (XNOR) view of the folded result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity3_fold
    import parity3_pkg::*;
(
    input  logic              acc,
    input  logic [BEAT_W-1:0] d,
    output logic              acc_next,
    output logic              parity_xnor
);

    assign acc_next    = acc ^ d[0] ^ d[1] ^ d[2];
    assign parity_xnor = ~acc_next;

endmodule

`default_nettype wire

// File: rtl/parity3_frame_acc.sv
// ============================================================================
// Module      : parity3_frame_acc
// Description : Streams 3-bit beats, folds parity over a frame and presents
//               one XNOR parity result per frame over valid/ready.
//               Optional expected-parity check: define PARITY3_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity3_frame_acc
    import parity3_pkg::*;
#(
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_parity,
    output logic [CNT_W-1:0]  out_beats,
    output logic              out_trunc,
    output logic              out_err
);

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(MAX_BEATS - 1);

    state_t           r_state;
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_parity;
    logic [CNT_W-1:0] r_beats;
    logic             r_trunc;

    logic             w_accept;
    logic             w_close;
    logic             w_acc_next;
    logic             w_parity_xnor;

    parity3_fold u_fold (
        .acc         (r_acc),
        .d           (in_data),
        .acc_next    (w_acc_next),
        .parity_xnor (w_parity_xnor)
    );

    // Handshake flags decode registered state only.
    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == HOLD);

    assign w_accept  = in_valid & in_ready;
    assign w_close   = in_last | (r_cnt == C_LAST_CNT);

`ifdef PARITY3_CHECK_EN
    logic r_exp;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ACC;
            r_acc    <= 1'b0;
            r_cnt    <= '0;
            r_parity <= 1'b0;
            r_beats  <= '0;
            r_trunc  <= 1'b0;
`ifdef PARITY3_CHECK_EN
            r_exp    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_close) begin
                            r_parity <= w_parity_xnor;
                            r_beats  <= r_cnt + 1'b1;
                            r_trunc  <= ~in_last;
`ifdef PARITY3_CHECK_EN
                            r_exp    <= in_exp;
`endif
                            r_state  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_acc   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ACC;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

    assign out_parity = r_parity;
    assign out_beats  = r_beats;
    assign out_trunc  = r_trunc;

`ifdef PARITY3_CHECK_EN
    assign out_err = r_parity ^ r_exp;
`else
    logic w_unused_exp;
    assign w_unused_exp = in_exp;
    assign out_err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity3_frame_acc.sv
// ============================================================================
// Module      : tb_parity3_frame_acc
// Description : Directed bench for parity3_frame_acc with a ones-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity3_frame_acc;

    localparam int MAXB = 16;
    localparam int CW   = 8;

`ifdef PARITY3_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_data;
    logic          in_last;
    logic          in_exp;
    logic          out_valid;
    logic          out_ready;
    logic          out_parity;
    logic [CW-1:0] out_beats;
    logic          out_trunc;
    logic          out_err;

    int n_vec = 0;
    int n_bad = 0;

    parity3_frame_acc #(.MAX_BEATS(MAXB), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .out_beats  (out_beats),
        .out_trunc  (out_trunc),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    // Model: count ones per frame; parity result is "ones count is even".
    bit m_hold = 0;
    int m_ones = 0;
    int m_beats = 0;
    bit e_parity = 0;
    int e_beats = 0;
    bit e_trunc = 0;
    bit e_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_hold = 0; m_ones = 0; m_beats = 0;
            e_parity = 0; e_beats = 0; e_trunc = 0; e_err = 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                m_ones  = m_ones + $countones(in_data);
                m_beats = m_beats + 1;
                if (in_last || m_beats == MAXB) begin
                    e_parity = (m_ones % 2) == 0;
                    e_beats  = m_beats;
                    e_trunc  = !in_last;
                    e_err    = CHK && (e_parity != in_exp);
                    m_hold   = 1;
                    m_ones   = 0;
                    m_beats  = 0;
                end
            end
        end else if (out_ready) begin
            m_hold = 0;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("m_in_ready",  32'(in_ready),   32'(!m_hold));
        cmp("m_out_valid", 32'(out_valid),  32'(m_hold));
        cmp("m_parity",    32'(out_parity), 32'(e_parity));
        cmp("m_beats",     32'(out_beats),  32'(e_beats));
        cmp("m_trunc",     32'(out_trunc),  32'(e_trunc));
        cmp("m_err",       32'(out_err),    32'(e_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_data  = 3'($urandom_range(0, 7));
        in_last  = 1'($urandom_range(0, 1));
        in_exp   = 1'($urandom_range(0, 1));
    endtask

    task automatic beat(input logic [2:0] d, input logic last, input logic e);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_exp   = e;
        tick();
        idle_inputs();
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        cmp(name, 32'(out_valid), 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        cmp("rst_in_ready", 32'(in_ready), 32'd1);
        cmp("rst_out_valid", 32'(out_valid), 32'd0);
        cmp("rst_beats", 32'(out_beats), 32'd0);
        cmp("rst_parity", 32'(out_parity), 32'd0);

        // Single beat 101: two ones -> even.
        beat(3'b101, 1'b1, 1'b1);
        cmp("t1_valid", 32'(out_valid), 32'd1);
        cmp("t1_parity", 32'(out_parity), 32'd1);
        cmp("t1_beats", 32'(out_beats), 32'd1);
        cmp("t1_trunc", 32'(out_trunc), 32'd0);
        release_result();
        cmp("t1_ready_back", 32'(in_ready), 32'd1);

        // Five ones -> odd.
        beat(3'b111, 1'b0, 1'b0);
        beat(3'b001, 1'b0, 1'b0);
        beat(3'b010, 1'b1, 1'b1);
        cmp("t2_parity", 32'(out_parity), 32'd0);
        cmp("t2_beats", 32'(out_beats), 32'd3);
        cmp("t2_err", 32'(out_err), 32'(CHK));
        release_result();

        // Force-close at MAX_BEATS.
        for (int i = 0; i < MAXB; i++) beat(3'b001, 1'b0, 1'b1);
        cmp("t3_valid", 32'(out_valid), 32'd1);
        cmp("t3_beats", 32'(out_beats), 32'd16);
        cmp("t3_trunc", 32'(out_trunc), 32'd1);
        cmp("t3_parity", 32'(out_parity), 32'd1);

        // Backpressure with a beat waiting upstream.
        in_valid = 1'b1; in_data = 3'b110; in_last = 1'b1; in_exp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp("t4_in_ready", 32'(in_ready), 32'd0);
            cmp("t4_beats_stable", 32'(out_beats), 32'd16);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cmp("t4_ready_rise", 32'(in_ready), 32'd1);
        tick();
        idle_inputs();
        cmp("t4_valid", 32'(out_valid), 32'd1);
        cmp("t4_beats", 32'(out_beats), 32'd1);
        cmp("t4_parity", 32'(out_parity), 32'd1);
        release_result();

        // Reset mid-frame.
        beat(3'b111, 1'b0, 1'b0);
        beat(3'b100, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("t5_out_valid", 32'(out_valid), 32'd0);
        cmp("t5_in_ready", 32'(in_ready), 32'd1);
        cmp("t5_beats", 32'(out_beats), 32'd0);
        beat(3'b000, 1'b1, 1'b1);
        wait_valid("t5_wait");
        cmp("t5_parity", 32'(out_parity), 32'd1);
        cmp("t5_beats1", 32'(out_beats), 32'd1);
        release_result();

        // Back-to-back frames with out_ready held high.
        out_ready = 1'b1;
        beat(3'b111, 1'b1, 1'b0);
        cmp("t6_f1_valid", 32'(out_valid), 32'd1);
        cmp("t6_f1_parity", 32'(out_parity), 32'd0);
        tick();
        cmp("t6_f1_drop", 32'(out_valid), 32'd0);
        beat(3'b100, 1'b0, 1'b1);
        beat(3'b100, 1'b1, 1'b1);
        cmp("t6_f2_parity", 32'(out_parity), 32'd1);
        cmp("t6_f2_beats", 32'(out_beats), 32'd2);
        tick();
        cmp("t6_f2_drop", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // in_last coinciding with MAX_BEATS is not a truncation.
        for (int i = 0; i < MAXB; i++) beat(3'b011, (i == MAXB - 1), 1'b0);
        cmp("t7_beats", 32'(out_beats), 32'd16);
        cmp("t7_trunc", 32'(out_trunc), 32'd0);
        cmp("t7_parity", 32'(out_parity), 32'd1);
        release_result();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
